// File: rtl/branch_update_ctrl.sv
// branch_update_ctrl
//   Sequences every write into the branch prediction buffer (target array and
//   local predictors). Execute-stage resolutions are queued in a small FIFO and
//   drained one per cycle. After reset or flush an initialisation sweep clears
//   every entry, and fetch-side predictions stay gated until it has finished.
//
//   Optional feature: define BRANCH_UPD_STATS_EN to build the saturating
//   target-miss and drop counters. Without it both counter outputs are tied to
//   zero and no counter flops exist.
module branch_update_ctrl #(
  parameter int ENTRIES = 1024,
  parameter int IDX_W   = 10,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_taken_i,
  input  logic             upd_tgt_miss_i,
  input  logic [1:0]       upd_hist_i,
  input  logic             flush_i,
  output logic             upd_ready_o,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic             wr_tgt_en_o,
  output logic [31:0]      wr_target_o,
  output logic             lp_en_o,
  output logic [1:0]       lp_hist_o,
  output logic             lp_taken_o,
  output logic             pred_valid_o,
  output logic [CNT_W-1:0] tgt_miss_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  // FIFO entry layout: {idx, target[31:0], taken, tgt_miss, hist[1:0]}
  localparam int ENT_W = IDX_W + 36;

  localparam logic [0:0]       ST_SWEEP = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [ENT_W-1:0] ENT_ZERO = {ENT_W{1'b0}};

  logic [0:0]       state_r;
  logic [IDX_W-1:0] sweep_idx_r;
  logic [ENT_W-1:0] fifo_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;

  logic             accept_s;
  logic             pop_s;
  logic             drop_s;
  logic [ENT_W-1:0] push_data_s;
  logic [ENT_W-1:0] head_s;
  logic [IDX_W-1:0] head_idx_s;
  logic [31:0]      head_target_s;
  logic             head_taken_s;
  logic             head_miss_s;
  logic [1:0]       head_hist_s;

  // Ready depends only on occupancy, so a pop in the same cycle never frees a full FIFO.
  assign upd_ready_o = (count_r != CNT_FULL);
  assign accept_s    = upd_valid_i && upd_ready_o && !flush_i;
  assign drop_s      = upd_valid_i && (!upd_ready_o || flush_i);
  // The queue only drains once the sweep has handed over to normal operation.
  assign pop_s       = (state_r == ST_RUN) && (count_r != CNT_ZERO) && !flush_i;

  assign push_data_s   = {upd_idx_i, upd_target_i, upd_taken_i, upd_tgt_miss_i, upd_hist_i};
  assign head_s        = fifo_mem_r[rd_ptr_r];
  assign head_hist_s   = head_s[1:0];
  assign head_miss_s   = head_s[2];
  assign head_taken_s  = head_s[3];
  assign head_target_s = head_s[35:4];
  assign head_idx_s    = head_s[ENT_W-1:36];

  // FIFO storage: write the accepted update at the tail slot.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= ENT_ZERO;
      end
    end else if (accept_s) begin
      fifo_mem_r[wr_ptr_r] <= push_data_s;
    end else begin
      fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy; flush discards everything queued.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (flush_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      wr_ptr_r <= accept_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sweep/run sequencing; the sweep index wraps back to zero as it finishes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= ST_SWEEP;
      sweep_idx_r <= IDX_ZERO;
    end else if (flush_i) begin
      state_r     <= ST_SWEEP;
      sweep_idx_r <= IDX_ZERO;
    end else begin
      case (state_r)
        ST_SWEEP: begin
          sweep_idx_r <= sweep_idx_r + IDX_ONE;
          state_r     <= (sweep_idx_r == LAST_IDX) ? ST_RUN : ST_SWEEP;
        end
        ST_RUN: begin
          sweep_idx_r <= sweep_idx_r;
          state_r     <= ST_RUN;
        end
        default: begin
          sweep_idx_r <= IDX_ZERO;
          state_r     <= ST_SWEEP;
        end
      endcase
    end
  end

  // Registered buffer write port and prediction gate.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_en_o      <= 1'b0;
      wr_idx_o     <= IDX_ZERO;
      wr_tgt_en_o  <= 1'b0;
      wr_target_o  <= 32'h0000_0000;
      lp_en_o      <= 1'b0;
      lp_hist_o    <= 2'b00;
      lp_taken_o   <= 1'b0;
      pred_valid_o <= 1'b0;
    end else if (flush_i) begin
      wr_en_o      <= 1'b0;
      wr_tgt_en_o  <= 1'b0;
      lp_en_o      <= 1'b0;
      pred_valid_o <= 1'b0;
    end else begin
      case (state_r)
        ST_SWEEP: begin
          // Clearing write: zero target and reset the entry's predictors.
          wr_en_o      <= 1'b1;
          wr_idx_o     <= sweep_idx_r;
          wr_tgt_en_o  <= 1'b1;
          wr_target_o  <= 32'h0000_0000;
          lp_en_o      <= 1'b0;
          pred_valid_o <= 1'b0;
        end
        ST_RUN: begin
          pred_valid_o <= 1'b1;
          if (pop_s) begin
            // A target miss replaces the entry; otherwise only the predictor steps.
            wr_en_o     <= 1'b1;
            wr_idx_o    <= head_idx_s;
            wr_tgt_en_o <= head_miss_s;
            wr_target_o <= head_target_s;
            lp_en_o     <= !head_miss_s;
            lp_hist_o   <= head_hist_s;
            lp_taken_o  <= head_taken_s;
          end else begin
            wr_en_o     <= 1'b0;
            wr_tgt_en_o <= 1'b0;
            lp_en_o     <= 1'b0;
          end
        end
        default: begin
          wr_en_o      <= 1'b0;
          wr_tgt_en_o  <= 1'b0;
          lp_en_o      <= 1'b0;
          pred_valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_UPD_STATS_EN
  localparam logic [CNT_W-1:0] STAT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] STAT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STAT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] tgt_miss_cnt_r;
  logic [CNT_W-1:0] drop_cnt_r;

  // Saturating statistics, cleared only by reset (flush leaves them alone).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tgt_miss_cnt_r <= STAT_ZERO;
      drop_cnt_r     <= STAT_ZERO;
    end else begin
      if (accept_s && upd_tgt_miss_i && (tgt_miss_cnt_r != STAT_MAX)) begin
        tgt_miss_cnt_r <= tgt_miss_cnt_r + STAT_ONE;
      end else begin
        tgt_miss_cnt_r <= tgt_miss_cnt_r;
      end
      if (drop_s && (drop_cnt_r != STAT_MAX)) begin
        drop_cnt_r <= drop_cnt_r + STAT_ONE;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign tgt_miss_cnt_o = tgt_miss_cnt_r;
  assign drop_cnt_o     = drop_cnt_r;
`else
  logic unused_stats_s;

  assign unused_stats_s = drop_s;
  assign tgt_miss_cnt_o = {CNT_W{1'b0}};
  assign drop_cnt_o     = {CNT_W{1'b0}};
`endif

endmodule
